// File: rtl/alu_share_ctrl_if.sv
// Bundle of requester, shared-ALU and response signals for alu_share_ctrl.
// The slave modport is the controller's view; master is the surrounding system.
interface alu_share_ctrl_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [2:0] req0_op;
  logic [7:0] req0_a;
  logic [7:0] req0_b;

  logic       req1_valid;
  logic       req1_ready;
  logic [2:0] req1_op;
  logic [7:0] req1_a;
  logic [7:0] req1_b;

  logic [2:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_y;

  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_data;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_op, alu_a, alu_b,
    input  alu_y,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_op, alu_a, alu_b,
    output alu_y,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin arbiter in front of one shared fixed-latency 8-bit ALU.
// One command is in flight at a time; the result is held until the consumer takes it.
module alu_share_ctrl #(
  parameter int unsigned ALU_LAT = 1  // 1..4
) (
  input logic             clk,
  input logic             rst,
  alu_share_ctrl_if.slave bus
);

  localparam logic [2:0] CntLoad = 3'(ALU_LAT);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e     r_state;
  logic [2:0] r_cnt;
  logic       r_last;       // requester granted most recently
  logic [2:0] r_op;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_id;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_data;

  logic w_idle;
  logic w_gnt0;
  logic w_gnt1;
  logic w_accept;

  // Combinational grant in IDLE only; on contention favour the requester not granted last.
  always_comb begin
    w_idle   = (r_state == StIdle) && !rst;
    w_gnt0   = w_idle && bus.req0_valid && (!bus.req1_valid || r_last);
    w_gnt1   = w_idle && bus.req1_valid && (!bus.req0_valid || !r_last);
    w_accept = w_gnt0 || w_gnt1;
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.alu_op     = r_op;
  assign bus.alu_a      = r_a;
  assign bus.alu_b      = r_b;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_id;
  assign bus.rsp_data   = r_rsp_data;

  // Transaction FSM: latch command, count ALU latency, hold the response until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= 3'd0;
      r_last      <= 1'b1;  // requester 0 wins the first contention
      r_op        <= 3'd0;
      r_a         <= 8'd0;
      r_b         <= 8'd0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_op    <= w_gnt0 ? bus.req0_op : bus.req1_op;
            r_a     <= w_gnt0 ? bus.req0_a  : bus.req1_a;
            r_b     <= w_gnt0 ? bus.req0_b  : bus.req1_b;
            r_id    <= w_gnt1;
            r_last  <= w_gnt1;
            r_cnt   <= CntLoad;
            r_state <= StWait;
          end
        end
        StWait: begin
          r_cnt <= r_cnt - 3'd1;
          // Counter hits zero on this edge: ALU output has settled for ALU_LAT cycles.
          if (r_cnt == 3'd1) begin
            r_rsp_data  <= bus.alu_y;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end
        end
        StResp: begin
          // Return to IDLE only; the next grant can happen one cycle later at the earliest.
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: one instance at ALU_LAT=1 and one at ALU_LAT=4
// share the same stimulus; 'sel' picks which one is observed.
module tb_alu_share_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sel = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic [2:0] req0_op = 3'd0, req1_op = 3'd0;
  logic [7:0] req0_a = 8'd0, req0_b = 8'd0, req1_a = 8'd0, req1_b = 8'd0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Stand-in for the shared ALU.
  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  alu_share_ctrl_if bus1 ();
  alu_share_ctrl_if bus4 ();

  assign bus1.req0_valid = req0_valid;
  assign bus1.req0_op    = req0_op;
  assign bus1.req0_a     = req0_a;
  assign bus1.req0_b     = req0_b;
  assign bus1.req1_valid = req1_valid;
  assign bus1.req1_op    = req1_op;
  assign bus1.req1_a     = req1_a;
  assign bus1.req1_b     = req1_b;
  assign bus1.rsp_ready  = rsp_ready;
  assign bus1.alu_y      = alu_ref(bus1.alu_op, bus1.alu_a, bus1.alu_b);

  assign bus4.req0_valid = req0_valid;
  assign bus4.req0_op    = req0_op;
  assign bus4.req0_a     = req0_a;
  assign bus4.req0_b     = req0_b;
  assign bus4.req1_valid = req1_valid;
  assign bus4.req1_op    = req1_op;
  assign bus4.req1_a     = req1_a;
  assign bus4.req1_b     = req1_b;
  assign bus4.rsp_ready  = rsp_ready;
  assign bus4.alu_y      = alu_ref(bus4.alu_op, bus4.alu_a, bus4.alu_b);

  alu_share_ctrl #(.ALU_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  alu_share_ctrl #(.ALU_LAT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  logic       o_r0, o_r1, o_rv, o_rid;
  logic [7:0] o_rd, o_a, o_b;
  logic [2:0] o_op;
  assign o_r0  = sel ? bus4.req0_ready : bus1.req0_ready;
  assign o_r1  = sel ? bus4.req1_ready : bus1.req1_ready;
  assign o_rv  = sel ? bus4.rsp_valid  : bus1.rsp_valid;
  assign o_rid = sel ? bus4.rsp_id     : bus1.rsp_id;
  assign o_rd  = sel ? bus4.rsp_data   : bus1.rsp_data;
  assign o_a   = sel ? bus4.alu_a      : bus1.alu_a;
  assign o_b   = sel ? bus4.alu_b      : bus1.alu_b;
  assign o_op  = sel ? bus4.alu_op     : bus1.alu_op;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic ready_of(input bit id);
    return id ? o_r1 : o_r0;
  endfunction

  task automatic set_req(input bit id, input logic v, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    if (!id) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  // Leaves the bench at posedge+1 with reset released and all requests idle.
  task automatic apply_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rsp_valid"}, 32'(o_rv), 0);
    chk({tag, " rsp_data"}, 32'(o_rd), 0);
    chk({tag, " rsp_id"}, 32'(o_rid), 0);
    chk({tag, " alu_op"}, 32'(o_op), 0);
    chk({tag, " alu_a"}, 32'(o_a), 0);
    chk({tag, " alu_b"}, 32'(o_b), 0);
    chk({tag, " req0_ready"}, 32'(o_r0), 0);
    chk({tag, " req1_ready"}, 32'(o_r1), 0);
  endtask

  typedef struct {
    bit         sel;
    bit         id;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[7];

  // Single isolated transactions with operand churn while the command is in flight.
  task automatic run_vectors();
    int lat;
    int e;
    bit seen;
    foreach (vecs[i]) begin
      sel = vecs[i].sel;
      lat = vecs[i].sel ? 4 : 1;
      apply_reset();
      set_req(vecs[i].id, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      @(negedge clk);
      chk("vec ready", 32'(ready_of(vecs[i].id)), 1);
      @(posedge clk); #1;
      set_req(vecs[i].id, 1'b0, 3'($urandom), 8'($urandom), 8'($urandom));
      e = 0; seen = 0;
      while (!seen && e < 10) begin
        @(negedge clk);
        chk("vec alu_a hold", 32'(o_a), 32'(vecs[i].a));
        chk("vec alu_op hold", 32'(o_op), 32'(vecs[i].op));
        if (o_rv) seen = 1;
        else begin
          @(posedge clk); #1;
          set_req(vecs[i].id, 1'b0, 3'($urandom), 8'($urandom), 8'($urandom));
          e++;
        end
      end
      chk("vec capture latency", 32'(e), 32'(lat));
      chk("vec rsp_data", 32'(o_rd), 32'(vecs[i].exp));
      chk("vec rsp_id", 32'(o_rid), 32'(vecs[i].id));
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("vec rsp_valid drop", 32'(o_rv), 0);
    end
  endtask

  // Both requesters always valid: grants alternate and arrive every ALU_LAT+2 cycles.
  task automatic contention(input bit s);
    int ids[$];
    int at[$];
    int c;
    int lat;
    sel = s;
    lat = s ? 4 : 1;
    apply_reset();
    set_req(1'b0, 1'b1, 3'd0, 8'h01, 8'h02);
    set_req(1'b1, 1'b1, 3'd1, 8'h09, 8'h04);
    rsp_ready = 1'b1;
    c = 0;
    while (ids.size() < 8 && c < 100) begin
      @(negedge clk);
      chk("contention single grant", 32'(o_r0 & o_r1), 0);
      if (o_r0) begin ids.push_back(0); at.push_back(c); end
      else if (o_r1) begin ids.push_back(1); at.push_back(c); end
      @(posedge clk); #1;
      c++;
    end
    chk("contention grant count", 32'(ids.size()), 8);
    foreach (ids[i]) chk("contention rr order", 32'(ids[i]), 32'(i % 2));
    for (int i = 1; i < at.size(); i++)
      chk("contention spacing", 32'(at[i] - at[i-1]), 32'(lat + 2));
    set_req(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
    set_req(1'b1, 1'b0, 3'd0, 8'd0, 8'd0);
    rsp_ready = 1'b0;
  endtask

  task automatic backpressure();
    bit seen;
    int k;
    sel = 1'b0;
    apply_reset();
    set_req(1'b0, 1'b1, 3'd0, 8'h11, 8'h22);
    @(negedge clk);
    chk("bp first ready", 32'(o_r0), 1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 3'd2, 8'h77, 8'h0F);
    set_req(1'b1, 1'b1, 3'd3, 8'h40, 8'h01);
    seen = 0; k = 0;
    while (!seen && k < 10) begin
      @(negedge clk);
      if (o_rv) seen = 1;
      else begin @(posedge clk); #1; k++; end
    end
    chk("bp response seen", 32'(seen), 1);
    for (int j = 0; j < 5; j++) begin
      chk("bp rsp_valid", 32'(o_rv), 1);
      chk("bp rsp_data", 32'(o_rd), 32'h33);
      chk("bp rsp_id", 32'(o_rid), 0);
      chk("bp req0_ready", 32'(o_r0), 0);
      chk("bp req1_ready", 32'(o_r1), 0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp release req0_ready", 32'(o_r0), 0);
    chk("bp release req1_ready", 32'(o_r1), 0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp idle rsp_valid", 32'(o_rv), 0);
    chk("bp next grant req1", 32'(o_r1), 1);
    chk("bp next grant not req0", 32'(o_r0), 0);
  endtask

  task automatic midop_reset();
    sel = 1'b1;
    apply_reset();
    set_req(1'b0, 1'b1, 3'd4, 8'h5A, 8'hC3);
    set_req(1'b1, 1'b1, 3'd0, 8'h01, 8'h01);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("midrst first grant", 32'(o_r0), 1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst alu_a before", 32'(o_a), 32'h5A);
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("midrst no stale rsp", 32'(o_rv), 0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("midrst contention req0", 32'(o_r0), 1);
    chk("midrst contention req1", 32'(o_r1), 0);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  // Random traffic against a timestamp-based transaction model.
  task automatic random_run(input bit s, input int ncyc);
    bit         m_busy;
    bit         m_last;
    bit         m_id;
    bit         win;
    bit         any;
    int         m_from;
    int         lat;
    logic [7:0] m_data, m_a, m_b;
    logic [2:0] m_op;
    logic       e0, e1, erv;
    m_busy = 0; m_last = 1; m_id = 0; m_from = 0;
    m_data = 0; m_a = 0; m_b = 0; m_op = 0;
    lat = s ? 4 : 1;
    sel = s;
    apply_reset();
    for (int c = 0; c < ncyc; c++) begin
      set_req(1'b0, $urandom_range(0, 3) != 0, 3'($urandom), 8'($urandom), 8'($urandom));
      set_req(1'b1, $urandom_range(0, 3) != 0, 3'($urandom), 8'($urandom), 8'($urandom));
      rsp_ready = $urandom_range(0, 2) != 0;
      @(negedge clk);
      e0 = 0; e1 = 0; erv = 0; any = 0; win = 0;
      if (!m_busy) begin
        any = req0_valid || req1_valid;
        if (req0_valid && req1_valid) win = !m_last;
        else win = req1_valid;
        e0 = any && !win;
        e1 = any && win;
      end else if (c >= m_from) begin
        erv = 1;
      end
      chk("rnd req0_ready", 32'(o_r0), 32'(e0));
      chk("rnd req1_ready", 32'(o_r1), 32'(e1));
      chk("rnd rsp_valid", 32'(o_rv), 32'(erv));
      chk("rnd alu_op", 32'(o_op), 32'(m_op));
      chk("rnd alu_a", 32'(o_a), 32'(m_a));
      chk("rnd alu_b", 32'(o_b), 32'(m_b));
      if (erv) begin
        chk("rnd rsp_data", 32'(o_rd), 32'(m_data));
        chk("rnd rsp_id", 32'(o_rid), 32'(m_id));
        if (rsp_ready) m_busy = 0;
      end
      if (any) begin
        m_busy = 1;
        m_from = c + 1 + lat;
        m_id   = win;
        m_last = win;
        m_op   = win ? req1_op : req0_op;
        m_a    = win ? req1_a  : req0_a;
        m_b    = win ? req1_b  : req0_b;
        m_data = alu_ref(m_op, m_a, m_b);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{sel: 1'b0, id: 1'b0, op: 3'd0, a: 8'h05, b: 8'h03, exp: 8'h08};
    vecs[1] = '{sel: 1'b1, id: 1'b1, op: 3'd0, a: 8'h10, b: 8'h22, exp: 8'h32};
    vecs[2] = '{sel: 1'b0, id: 1'b1, op: 3'd1, a: 8'h10, b: 8'h01, exp: 8'h0F};
    vecs[3] = '{sel: 1'b1, id: 1'b0, op: 3'd4, a: 8'hF0, b: 8'hFF, exp: 8'h0F};
    vecs[4] = '{sel: 1'b0, id: 1'b0, op: 3'd2, a: 8'h3C, b: 8'h0F, exp: 8'h0C};
    vecs[5] = '{sel: 1'b1, id: 1'b1, op: 3'd3, a: 8'hA0, b: 8'h05, exp: 8'hA5};
    vecs[6] = '{sel: 1'b0, id: 1'b1, op: 3'd5, a: 8'h5A, b: 8'h00, exp: 8'hA5};

    // Reset state with both requesters pushing: nothing may leak out.
    #1 rst = 1'b1;
    set_req(1'b0, 1'b1, 3'd7, 8'hAA, 8'h55);
    set_req(1'b1, 1'b1, 3'd6, 8'h33, 8'hCC);
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sel = 1'b0;
    #1 chk_all_zero("reset lat1");
    sel = 1'b1;
    #1 chk_all_zero("reset lat4");

    run_vectors();
    contention(1'b0);
    contention(1'b1);
    backpressure();
    midop_reset();
    random_run(1'b0, 600);
    random_run(1'b1, 600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
